dmem_port_arbiter: RTL and testbench



---
 rtl/dmem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_port_arbiter
// Brief   : Shares the single-port data memory between the core load/store
//           path and a debug/loader port. The core has fixed priority, an
//           anti-starvation counter lets waiting debug traffic through, and
//           debug can lock the memory for exclusive use.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              locked,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // MAX_HOLD is limited to 1..15, so four bits always hold the count.
  localparam int                  c_hold_w   = 4;
  localparam logic [c_hold_w-1:0] c_max_hold = c_hold_w'(MAX_HOLD);

  typedef enum logic [0:0] {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  owner_t              w_owner_nxt;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [c_hold_w-1:0] w_hold_cnt_nxt;
  logic                w_core_win;
  logic                w_dbg_win;
  logic                r_core_rvalid;
  logic                r_dbg_rvalid;
  logic [DATA_W-1:0]   r_core_rdata;
  logic [DATA_W-1:0]   r_dbg_rdata;

  // --------------------------------------------------------------------------
  // Arbitration and next-state decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_core_win  = 1'b0;
    w_dbg_win   = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_OPEN: begin
        // Core keeps priority until debug has waited through MAX_HOLD core grants.
        if (core_req && !(dbg_req && (r_hold_cnt == c_max_hold))) begin
          w_core_win = 1'b1;
        end else if (dbg_req) begin
          w_dbg_win = 1'b1;
        end
        if (w_dbg_win && dbg_lock) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        w_dbg_win = dbg_req;
        if (!dbg_lock) begin
          w_state_nxt = ST_OPEN;
        end
      end
      default: w_state_nxt = ST_OPEN;
    endcase
  end

  always_comb begin
    w_hold_cnt_nxt = r_hold_cnt;
    if (!dbg_req || w_dbg_win) begin
      w_hold_cnt_nxt = '0;
    end else if (w_core_win && (r_hold_cnt != c_max_hold)) begin
      w_hold_cnt_nxt = r_hold_cnt + 1'b1;
    end
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_core_win && !core_we) begin
      w_owner_nxt = OWN_CORE;
    end else if (w_dbg_win && !dbg_we) begin
      w_owner_nxt = OWN_DBG;
    end
  end

  // --------------------------------------------------------------------------
  // Memory-side mux: idle cycles drive all zeros
  // --------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_core_win) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (w_dbg_win) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_OPEN;
      r_hold_cnt <= '0;
      r_owner    <= OWN_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_owner    <= w_owner_nxt;
    end
  end

  // Read data arrives the cycle after the grant; capture it for the owner only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_core_rvalid <= 1'b0;
      r_dbg_rvalid  <= 1'b0;
      r_core_rdata  <= '0;
      r_dbg_rdata   <= '0;
    end else begin
      r_core_rvalid <= (r_owner == OWN_CORE);
      r_dbg_rvalid  <= (r_owner == OWN_DBG);
      if (r_owner == OWN_CORE) begin
        r_core_rdata <= mem_rdata;
      end
      if (r_owner == OWN_DBG) begin
        r_dbg_rdata <= mem_rdata;
      end
    end
  end

  assign core_gnt    = w_core_win;
  assign dbg_gnt     = w_dbg_win;
  assign core_stall  = core_req & ~w_core_win;
  assign core_rvalid = r_core_rvalid;
  assign core_rdata  = r_core_rdata;
  assign dbg_rvalid  = r_dbg_rvalid;
  assign dbg_rdata   = r_dbg_rdata;
  assign locked      = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_port_arbiter
// Brief   : Randomized and directed bench for dmem_port_arbiter against a
//           transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [9:0]  core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        core_gnt, core_rvalid, core_stall;
  logic [31:0] core_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [9:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_gnt, dbg_rvalid, locked;
  logic [31:0] dbg_rdata;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .locked(locked),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory: read data valid the cycle after the address.
  logic [31:0] env_mem [1024];
  always @(posedge clk) begin
    if (mem_we) env_mem[mem_addr] <= mem_wdata;
    mem_rdata <= env_mem[mem_addr];
  end

  // Reference model: memory image, pending responses and arbitration bookkeeping.
  typedef struct { bit is_dbg; logic [31:0] data; int due; } resp_t;
  logic [31:0] exp_mem [1024];
  resp_t       rq[$];
  bit          m_locked = 0;
  int          m_streak = 0;
  int          cyc = 0;
  logic [31:0] m_core_rdata = '0, m_dbg_rdata = '0;

  logic        e_cgnt, e_dgnt, e_stall, e_mwe, e_crv, e_drv, e_locked;
  logic [9:0]  e_maddr;
  logic [31:0] e_mwd, e_crd, e_drd;
  logic        o_cgnt, o_dgnt, o_stall, o_mwe, o_crv, o_drv, o_locked;
  logic [9:0]  o_maddr;
  logic [31:0] o_mwd, o_crd, o_drd;

  // One bus cycle: drive at posedge+1, sample at negedge, then advance the model.
  task automatic step(input logic cr, input logic cwe, input logic [9:0] ca, input logic [31:0] cwd,
                      input logic dr, input logic dwe, input logic dl, input logic [9:0] da,
                      input logic [31:0] dwd);
    int    winner;
    resp_t r;
    core_req = cr; core_we = cwe; core_addr = ca; core_wdata = cwd;
    dbg_req = dr; dbg_we = dwe; dbg_lock = dl; dbg_addr = da; dbg_wdata = dwd;
    @(negedge clk);
    if (m_locked)                                   winner = dr ? 2 : 0;
    else if (cr && !(dr && m_streak == MAX_HOLD))  winner = 1;
    else if (dr)                                    winner = 2;
    else                                            winner = 0;
    e_cgnt = (winner == 1); e_dgnt = (winner == 2);
    e_stall = cr && (winner != 1); e_locked = m_locked;
    e_mwe   = (winner == 1) ? cwe : (winner == 2) ? dwe : 1'b0;
    e_maddr = (winner == 1) ? ca  : (winner == 2) ? da  : 10'd0;
    e_mwd   = (winner == 1) ? cwd : (winner == 2) ? dwd : 32'd0;
    e_crv = 1'b0; e_drv = 1'b0;
    while (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.is_dbg) begin e_drv = 1'b1; m_dbg_rdata = r.data; end
      else begin e_crv = 1'b1; m_core_rdata = r.data; end
    end
    e_crd = m_core_rdata; e_drd = m_dbg_rdata;
    o_cgnt = core_gnt; o_dgnt = dbg_gnt; o_stall = core_stall; o_mwe = mem_we;
    o_crv = core_rvalid; o_drv = dbg_rvalid; o_locked = locked;
    o_maddr = mem_addr; o_mwd = mem_wdata; o_crd = core_rdata; o_drd = dbg_rdata;
    if (winner == 1 && !cwe) begin r.is_dbg = 0; r.data = exp_mem[ca]; r.due = cyc + 2; rq.push_back(r); end
    if (winner == 2 && !dwe) begin r.is_dbg = 1; r.data = exp_mem[da]; r.due = cyc + 2; rq.push_back(r); end
    if (winner == 1 && cwe) exp_mem[ca] = cwd;
    if (winner == 2 && dwe) exp_mem[da] = dwd;
    if (!dr || winner == 2) m_streak = 0;
    else if (winner == 1 && m_streak < MAX_HOLD) m_streak++;
    if (!m_locked && winner == 2 && dl) m_locked = 1;
    else if (m_locked && !dl) m_locked = 0;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic model_reset();
    rq.delete(); m_locked = 0; m_streak = 0; m_core_rdata = '0; m_dbg_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({core_rvalid, dbg_rvalid, locked, mem_we, core_gnt, dbg_gnt} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctl: got %b required 000000",
                        {core_rvalid, dbg_rvalid, locked, mem_we, core_gnt, dbg_gnt});
    end
    n_cmp++;
    if (core_rdata !== 32'd0 || dbg_rdata !== 32'd0) begin
      n_bad++; $display("FAIL reset_rdata: core=%h dbg=%h required 0", core_rdata, dbg_rdata);
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_core_read();
    step(1'b1, 1'b0, 10'd20, 32'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    n_cmp++;
    if (o_cgnt !== 1'b1 || o_maddr !== 10'd20 || o_mwe !== 1'b0) begin
      n_bad++; $display("FAIL core_rd_gnt: gnt=%b addr=%0d we=%b required 1/20/0", o_cgnt, o_maddr, o_mwe);
    end
    idle();
    n_cmp++;
    if (o_crv !== 1'b0) begin n_bad++; $display("FAIL core_rd_early: rvalid=%b required 0", o_crv); end
    idle();
    n_cmp++;
    if (o_crv !== 1'b1 || o_crd !== 32'd25 || o_drv !== 1'b0) begin
      n_bad++; $display("FAIL core_rd_resp: rvalid=%b rdata=%0d dbg_rvalid=%b required 1/25/0", o_crv, o_crd, o_drv);
    end
  endtask

  task automatic test_write_then_dbg_read();
    step(1'b1, 1'b1, 10'd1, 32'hA, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    n_cmp++;
    if (o_mwe !== 1'b1 || o_maddr !== 10'd1 || o_mwd !== 32'hA || o_stall !== 1'b0) begin
      n_bad++; $display("FAIL core_wr: we=%b addr=%0d wdata=%h stall=%b required 1/1/a/0", o_mwe, o_maddr, o_mwd, o_stall);
    end
    step(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 10'd1, 32'd0);
    n_cmp++;
    if (o_dgnt !== 1'b1 || o_cgnt !== 1'b0 || o_maddr !== 10'd1) begin
      n_bad++; $display("FAIL dbg_rd_gnt: dbg_gnt=%b core_gnt=%b addr=%0d required 1/0/1", o_dgnt, o_cgnt, o_maddr);
    end
    idle();
    idle();
    n_cmp++;
    if (o_drv !== 1'b1 || o_drd !== 32'hA || o_stall !== 1'b0 || o_crv !== 1'b0) begin
      n_bad++; $display("FAIL dbg_rd_resp: rvalid=%b rdata=%h stall=%b core_rvalid=%b required 1/a/0/0",
                        o_drv, o_drd, o_stall, o_crv);
    end
  endtask

  task automatic test_starvation();
    logic [9:0] pat;
    int ci, di, nc, nd;
    pat = 10'b10000_10000;
    ci = 0; di = 0; nc = 0; nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) step(1'b1, 1'b0, 10'(ci), 32'd0, 1'b1, 1'b0, 1'b0, 10'(40 + di), 32'd0);
      else idle();
      if (o_crv) nc++;
      if (o_drv) nd++;
      if (i < 10) begin
        n_cmp++;
        if (o_dgnt !== pat[i] || o_cgnt !== ~pat[i] || o_stall !== pat[i]) begin
          n_bad++; $display("FAIL starve_gnt cycle %0d: core_gnt=%b dbg_gnt=%b stall=%b required dbg_gnt=%b",
                            i, o_cgnt, o_dgnt, o_stall, pat[i]);
        end
        if (o_cgnt) ci++;
        if (o_dgnt) di++;
      end
      if (o_drv) begin
        n_cmp++;
        if (o_drd !== e_drd) begin n_bad++; $display("FAIL starve_dbg_data: got %h required %h", o_drd, e_drd); end
      end
    end
    n_cmp++;
    if (nd != 2 || nc != 8) begin
      n_bad++; $display("FAIL starve_rvalid_count: dbg=%0d core=%0d required 2/8", nd, nc);
    end
  endtask

  task automatic test_lock();
    // dbg_lock alone, without a debug grant, must not lock.
    step(1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b0, 1'b1, 10'd0, 32'd0);
    n_cmp++;
    if (o_cgnt !== 1'b1) begin n_bad++; $display("FAIL lock_noreq_gnt: core_gnt=%b required 1", o_cgnt); end
    idle();
    n_cmp++;
    if (o_locked !== 1'b0) begin n_bad++; $display("FAIL lock_noreq: locked=%b required 0", o_locked); end
    idle();
    step(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b1, 1'b1, 10'd2, 32'd9);
    n_cmp++;
    if (o_dgnt !== 1'b1 || o_locked !== 1'b0 || o_mwe !== 1'b1) begin
      n_bad++; $display("FAIL lock_entry: dbg_gnt=%b locked=%b we=%b required 1/0/1", o_dgnt, o_locked, o_mwe);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 10'd0, 32'd0, 1'b1, 1'b1, 1'b1, 10'(30 + i), 32'(100 + i));
      n_cmp++;
      if (o_locked !== 1'b1 || o_cgnt !== 1'b0 || o_stall !== 1'b1 || o_dgnt !== 1'b1) begin
        n_bad++; $display("FAIL lock_hold %0d: locked=%b core_gnt=%b stall=%b dbg_gnt=%b required 1/0/1/1",
                          i, o_locked, o_cgnt, o_stall, o_dgnt);
      end
    end
    step(1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    n_cmp++;
    if (o_locked !== 1'b1 || o_cgnt !== 1'b0 || o_stall !== 1'b1) begin
      n_bad++; $display("FAIL lock_exit_cycle: locked=%b core_gnt=%b stall=%b required 1/0/1", o_locked, o_cgnt, o_stall);
    end
    step(1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    n_cmp++;
    if (o_locked !== 1'b0 || o_cgnt !== 1'b1) begin
      n_bad++; $display("FAIL lock_after_exit: locked=%b core_gnt=%b required 0/1", o_locked, o_cgnt);
    end
    idle();
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [3];
    int k;
    want[0] = 32'd0; want[1] = 32'd10; want[2] = 32'd9;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(1'b1, 1'b0, 10'(i), 32'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
      else idle();
      if (i >= 2) begin
        n_cmp++;
        if (o_crv !== 1'b1 || o_crd !== want[k]) begin
          n_bad++; $display("FAIL b2b_read %0d: rvalid=%b rdata=%0d required 1/%0d", k, o_crv, o_crd, want[k]);
        end
        k++;
      end
    end
  endtask

  task automatic test_reset_mid_read();
    step(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 10'd20, 32'd0);
    n_cmp++;
    if (o_dgnt !== 1'b1) begin n_bad++; $display("FAIL rst_mid_gnt: dbg_gnt=%b required 1", o_dgnt); end
    core_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0; dbg_we = 1'b0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dbg_rvalid !== 1'b0 || locked !== 1'b0 || mem_we !== 1'b0 || dbg_rdata !== 32'd0) begin
        n_bad++; $display("FAIL rst_mid %0d: rvalid=%b locked=%b we=%b rdata=%h required 0/0/0/0",
                          i, dbg_rvalid, locked, mem_we, dbg_rdata);
      end
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      idle();
      n_cmp++;
      if (o_drv !== 1'b0 || o_crv !== 1'b0) begin
        n_bad++; $display("FAIL rst_mid_stale: dbg_rvalid=%b core_rvalid=%b required 0/0", o_drv, o_crv);
      end
    end
    step(1'b1, 1'b0, 10'd20, 32'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    idle();
    idle();
    n_cmp++;
    if (o_crv !== 1'b1 || o_crd !== 32'd25) begin
      n_bad++; $display("FAIL rst_mid_after: rvalid=%b rdata=%0d required 1/25", o_crv, o_crd);
    end
  endtask

  task automatic test_random();
    logic cp, cw, dp, dw, dl;
    logic [9:0]  ca, da;
    logic [31:0] cd, dd;
    cp = 0; cw = 0; dp = 0; dw = 0; dl = 0; ca = '0; da = '0; cd = '0; dd = '0;
    for (int i = 0; i < 410; i++) begin
      if (i < 400 && !cp && $urandom_range(0, 99) < 60) begin
        cp = 1; cw = 1'($urandom_range(0, 1)); ca = 10'($urandom_range(0, 15)); cd = $urandom;
      end
      if (i < 400 && !dp && $urandom_range(0, 99) < 45) begin
        dp = 1; dw = 1'($urandom_range(0, 1)); da = 10'($urandom_range(0, 15)); dd = $urandom;
      end
      if (i >= 400) dl = 0;
      else dl = m_locked ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 15);
      step(cp, cw, ca, cd, dp, dw, dl, da, dd);
      n_cmp++;
      if ({o_cgnt, o_dgnt, o_stall, o_mwe, o_crv, o_drv, o_locked} !==
          {e_cgnt, e_dgnt, e_stall, e_mwe, e_crv, e_drv, e_locked}) begin
        n_bad++; $display("FAIL rnd_ctl cycle %0d: got %b required %b (gnt_c,gnt_d,stall,we,rv_c,rv_d,locked)", i,
                          {o_cgnt, o_dgnt, o_stall, o_mwe, o_crv, o_drv, o_locked},
                          {e_cgnt, e_dgnt, e_stall, e_mwe, e_crv, e_drv, e_locked});
      end
      n_cmp++;
      if (o_maddr !== e_maddr || o_mwd !== e_mwd) begin
        n_bad++; $display("FAIL rnd_membus cycle %0d: addr=%0d wdata=%h required %0d/%h", i, o_maddr, o_mwd, e_maddr, e_mwd);
      end
      n_cmp++;
      if (o_crd !== e_crd || o_drd !== e_drd) begin
        n_bad++; $display("FAIL rnd_rdata cycle %0d: core=%h dbg=%h required %h/%h", i, o_crd, o_drd, e_crd, e_drd);
      end
      if (o_cgnt) cp = 0;
      if (o_dgnt) dp = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = (i == 0) ? 32'd0 : 32'(i + 5);
      exp_mem[i] = (i == 0) ? 32'd0 : 32'(i + 5);
    end
    test_reset();
    test_core_read();
    test_write_then_dbg_read();
    test_starvation();
    test_lock();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
